// File: rtl/psx_host_port_pkg.sv
// Shared PSX link constants, FSM state encoding and the timer-load helper.
package psx_host_port_pkg;

    localparam int DEF_CLOCK_MHZ      = 25;
    localparam int DEF_HALF_US        = 2;
    localparam int DEF_SEL_SETUP_US   = 10;
    localparam int DEF_GAP_US         = 10;
    localparam int DEF_ACK_TIMEOUT_US = 100;
    localparam int DEF_DESEL_US       = 20;

    localparam int TMR_W = 12;

    localparam logic [7:0] PADDING_BYTE = 8'h5A;
    localparam logic [3:0] MODE_DIGITAL = 4'h4;
    localparam logic [3:0] MODE_ANALOG  = 4'h7;
    localparam logic [3:0] MODE_ESCAPE  = 4'hF;
    localparam logic [7:0] ADDR_PORT1   = 8'h01;
    localparam logic [7:0] CMD_POLL     = 8'h42;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_ACKW,
        ST_GAP,
        ST_DESEL
    } psx_state_t;

    // A phase of N cycles is loaded as N-1 and ends on the cycle the timer reads zero.
    function automatic logic [TMR_W-1:0] us_to_load(input int mhz, input int us);
        int n;
        n = mhz * us - 1;
        return n[TMR_W-1:0];
    endfunction

endpackage

// File: rtl/psx_host_port_if.sv
// Host-side byte stream of the PSX port: command bytes in, reply bytes and status out.
interface psx_host_port_if;
    logic [7:0] cmd_byte;
    logic       cmd_last;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] reply_byte;
    logic       reply_acked;
    logic       reply_valid;
    logic       busy;
    logic       timeout;

    modport master (
        output cmd_byte, cmd_last, cmd_valid,
        input  cmd_ready, reply_byte, reply_acked, reply_valid, busy, timeout
    );

    modport slave (
        input  cmd_byte, cmd_last, cmd_valid,
        output cmd_ready, reply_byte, reply_acked, reply_valid, busy, timeout
    );
endinterface

// File: rtl/psx_input_sync.sv
// Two-flop synchroniser for an asynchronous pulled-up PSX pin; resets to 1.
// Latency: 2 clk cycles. No backpressure.
module psx_input_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], async_in};
        end
    end

    assign sync_out = sync_q[1];
endmodule

// File: rtl/psx_host_port.sv
// Initiator end of the PSX controller link: one command byte out, one reply byte in.
// Latency: setup + 16 half periods per byte; reply strobes after ACK, timeout or last bit.
// Backpressure: cmd_ready only in IDLE or after the inter-byte gap; stalls in GAP hold pins.
module psx_host_port
    import psx_host_port_pkg::*;
#(
    parameter int CLOCK_MHZ      = DEF_CLOCK_MHZ,
    parameter int HALF_US        = DEF_HALF_US,
    parameter int SEL_SETUP_US   = DEF_SEL_SETUP_US,
    parameter int GAP_US         = DEF_GAP_US,
    parameter int ACK_TIMEOUT_US = DEF_ACK_TIMEOUT_US,
    parameter int DESEL_US       = DEF_DESEL_US
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          PSX_ack,
    input  logic          PSX_dat,
    output logic          PSX_clk,
    output logic          PSX_sel,
    output logic          PSX_cmd,
    psx_host_port_if.slave host
);
    localparam logic [TMR_W-1:0] LD_HALF  = us_to_load(CLOCK_MHZ, HALF_US);
    localparam logic [TMR_W-1:0] LD_SETUP = us_to_load(CLOCK_MHZ, SEL_SETUP_US);
    localparam logic [TMR_W-1:0] LD_GAP   = us_to_load(CLOCK_MHZ, GAP_US);
    localparam logic [TMR_W-1:0] LD_ACK   = us_to_load(CLOCK_MHZ, ACK_TIMEOUT_US);
    localparam logic [TMR_W-1:0] LD_DESEL = us_to_load(CLOCK_MHZ, DESEL_US);

    logic ack_s;
    logic dat_s;

    psx_input_sync u_ack_sync (.clk(clk), .reset(reset), .async_in(PSX_ack), .sync_out(ack_s));
    psx_input_sync u_dat_sync (.clk(clk), .reset(reset), .async_in(PSX_dat), .sync_out(dat_s));

    psx_state_t       state_q, state_nx;
    logic [TMR_W-1:0] tmr_q, tmr_nx;
    logic [2:0]       bit_idx_q, bit_idx_nx;
    logic [7:0]       shift_q, shift_nx;
    logic             last_q, last_nx;
    logic             ack_seen_q, ack_seen_nx;
    logic             psx_clk_q, psx_clk_nx;
    logic             psx_sel_q, psx_sel_nx;
    logic             psx_cmd_q, psx_cmd_nx;
    logic [7:0]       reply_byte_q, reply_byte_nx;
    logic             reply_acked_q, reply_acked_nx;
    logic             reply_valid_q, reply_valid_nx;
    logic             timeout_q, timeout_nx;
    logic             cmd_ready;
    logic             tmr_done;

    assign tmr_done = (tmr_q == '0);

    always_comb begin
        state_nx       = state_q;
        tmr_nx         = tmr_done ? tmr_q : tmr_q - 1'b1;
        bit_idx_nx     = bit_idx_q;
        shift_nx       = shift_q;
        last_nx        = last_q;
        ack_seen_nx    = ack_seen_q;
        reply_byte_nx  = reply_byte_q;
        reply_acked_nx = reply_acked_q;
        reply_valid_nx = 1'b0;
        timeout_nx     = 1'b0;
        cmd_ready      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (host.cmd_valid) begin
                    shift_nx = host.cmd_byte;
                    last_nx  = host.cmd_last;
                    tmr_nx   = LD_SETUP;
                    state_nx = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    bit_idx_nx = 3'd0;
                    tmr_nx     = LD_HALF;
                    state_nx   = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tmr_done) begin
                    tmr_nx   = LD_HALF;
                    state_nx = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tmr_done) begin
                    // The same register shifts the command out and the reply in, LSB first.
                    shift_nx = {dat_s, shift_q[7:1]};
                    if (bit_idx_q != 3'd7) begin
                        bit_idx_nx = bit_idx_q + 3'd1;
                        tmr_nx     = LD_HALF;
                        state_nx   = ST_LOW;
                    end else if (last_q) begin
                        reply_valid_nx = 1'b1;
                        reply_byte_nx  = shift_nx;
                        reply_acked_nx = 1'b0;
                        tmr_nx         = LD_DESEL;
                        state_nx       = ST_DESEL;
                    end else begin
                        ack_seen_nx = 1'b0;
                        tmr_nx      = LD_ACK;
                        state_nx    = ST_ACKW;
                    end
                end
            end
            ST_ACKW: begin
                if (ack_seen_q && ack_s) begin
                    reply_valid_nx = 1'b1;
                    reply_byte_nx  = shift_q;
                    reply_acked_nx = 1'b1;
                    tmr_nx         = LD_GAP;
                    state_nx       = ST_GAP;
                end else if (tmr_done) begin
                    timeout_nx     = 1'b1;
                    reply_valid_nx = 1'b1;
                    reply_byte_nx  = shift_q;
                    reply_acked_nx = 1'b0;
                    tmr_nx         = LD_DESEL;
                    state_nx       = ST_DESEL;
                end else if (!ack_s) begin
                    ack_seen_nx = 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_done) begin
                    cmd_ready = 1'b1;
                    if (host.cmd_valid) begin
                        shift_nx   = host.cmd_byte;
                        last_nx    = host.cmd_last;
                        bit_idx_nx = 3'd0;
                        tmr_nx     = LD_HALF;
                        state_nx   = ST_LOW;
                    end
                end
            end
            ST_DESEL: begin
                if (tmr_done) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Pins are registered from the next state so they switch on the same edge as the FSM.
        psx_clk_nx = (state_nx != ST_LOW);
        psx_sel_nx = (state_nx == ST_IDLE) || (state_nx == ST_DESEL);
        if (psx_sel_nx) begin
            psx_cmd_nx = 1'b1;
        end else if ((state_nx == ST_LOW) && (state_q != ST_LOW)) begin
            psx_cmd_nx = shift_nx[0];
        end else begin
            psx_cmd_nx = psx_cmd_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            tmr_q         <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            last_q        <= 1'b0;
            ack_seen_q    <= 1'b0;
            psx_clk_q     <= 1'b1;
            psx_sel_q     <= 1'b1;
            psx_cmd_q     <= 1'b1;
            reply_byte_q  <= 8'h00;
            reply_acked_q <= 1'b0;
            reply_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_nx;
            tmr_q         <= tmr_nx;
            bit_idx_q     <= bit_idx_nx;
            shift_q       <= shift_nx;
            last_q        <= last_nx;
            ack_seen_q    <= ack_seen_nx;
            psx_clk_q     <= psx_clk_nx;
            psx_sel_q     <= psx_sel_nx;
            psx_cmd_q     <= psx_cmd_nx;
            reply_byte_q  <= reply_byte_nx;
            reply_acked_q <= reply_acked_nx;
            reply_valid_q <= reply_valid_nx;
            timeout_q     <= timeout_nx;
        end
    end

    assign PSX_clk          = psx_clk_q;
    assign PSX_sel          = psx_sel_q;
    assign PSX_cmd          = psx_cmd_q;
    assign host.cmd_ready   = cmd_ready;
    assign host.reply_byte  = reply_byte_q;
    assign host.reply_acked = reply_acked_q;
    assign host.reply_valid = reply_valid_q;
    assign host.timeout     = timeout_q;
    assign host.busy        = (state_q != ST_IDLE);
endmodule
